pc_unit: RTL and testbench
==========================

// Module: pc_unit
// PURPOSE
//  Program-counter stage downstream of the multicycle control FSM. Holds the PC, the address of the
//  in-flight instruction and the JAL link value; applies increment, PC-relative branch, register jump
//  and jump-and-link updates from the FSM's PC strobes. Drives the instruction-fetch address and the link
//  value consumed by the result mux (result select 2'b11).
// PARAMETERS
//  ADDR_W      16      PC / memory address width; all PC arithmetic is modulo 2**ADDR_W
//  DISP_W      8       branch displacement width (two's complement, word units)
//  RESET_VEC   0       PC value loaded on reset
// PORTS
//  clk              in   1        clock
//  reset            in   1        synchronous, active-low reset
//  PCEN             in   1        PC write enable from control FSM
//  PCinstruction    in   1        PC-update request from control FSM
//  nextInstruction  in   1        high during fetch states; qualifies plain increment
//  BranchEN         in   1        conditional branch taken (condition already evaluated)
//  JmpEN            in   1        conditional register jump taken
//  JALEN            in   1        jump-and-link
//  stall            in   1        freezes all registers (memory wait)
//  disp             in   DISP_W   branch displacement from immediate field
//  rtarget          in   ADDR_W   target register value (Rtarget read port)
//  pc               out  ADDR_W   current PC = fetch address
//  inst_pc          out  ADDR_W   address of instruction being executed
//  link             out  ADDR_W   return address written by JAL
//  redirect         out  1        one-cycle pulse: PC loaded with non-sequential value
// BEHAVIOUR
//  Reset (reset==0 at posedge): pc=RESET_VEC, inst_pc=RESET_VEC, link=0, redirect=0; overrides stall.
//  All updates on posedge clk, registered outputs, no combinational path input->output.
//  stall==1: pc, inst_pc, link hold; redirect=0.
//  Update happens only when PCEN && PCinstruction && !stall; otherwise pc holds. Priority, highest first:
//   1 JALEN:            link<=pc; pc<=rtarget; redirect<=1
//   2 JmpEN:            pc<=rtarget; redirect<=1
//   3 BranchEN:         pc<=inst_pc + sext(disp); redirect<=1
//   4 nextInstruction:  inst_pc<=pc; pc<=pc+1; redirect<=0   (fetch increment)
//   5 none:             pc holds (branch/jump not taken in execute state); redirect<=0
//  pc already points past the instruction when execute states run, so link = inst_pc+1 = return address.
//  Branch target is relative to inst_pc, not pc. disp sign-extended to ADDR_W, sum truncated (wraps:
//   inst_pc=0x0000, disp=0xFF -> 0xFFFF; inst_pc=0xFFFF, +1 increment -> 0x0000).
//  Multiple of JALEN/JmpEN/BranchEN high together: priority above applies; FSM never does this.
//  BranchEN/JmpEN/JALEN with PCEN low: ignored.
//  redirect high exactly one cycle after a taken load; cleared by any non-redirect cycle or stall.
//  Reset asserted mid-instruction: state discarded, next cycle fetch restarts at RESET_VEC.
// STRUCTURE
//  Shared package: ADDR_W, DISP_W, RESET_VEC defaults; localparam PC_INC=1.
//  One sub-module: pc_target_gen (combinational sext + adder + priority mux producing next_pc,
//  load_link, redirect_next); pc_unit holds the three registers and stall/reset gating.
// TESTING
//  Reset then 3 fetch strobes (PCEN,PCinstruction,nextInstruction=1) -> pc 0,1,2,3; inst_pc 0,0,1,2.
//  inst_pc=0x0010, BranchEN, disp=0xFC -> pc=0x000C, redirect=1 for one cycle.
//  BCONDEX-style not taken: PCEN=PCinstruction=1, all EN=0, nextInstruction=0 -> pc unchanged.
//  pc=0x0021, JALEN, rtarget=0x0400 -> pc=0x0400, link=0x0021; JmpEN then rtarget=0x0021 -> pc=0x0021.
//  stall=1 with fetch strobe and with JALEN -> pc, inst_pc, link unchanged, redirect=0.
//  pc=0xFFFF fetch -> 0x0000; reset=0 mid-stream with JALEN high -> pc=RESET_VEC, link=0.

Source files
------------

// File: rtl/pc_unit_pkg.sv
// Shared defaults for the program-counter stage.
// Address/displacement widths, reset vector and the sequential increment.
package pc_unit_pkg;

    localparam int DEF_ADDR_W    = 16;
    localparam int DEF_DISP_W    = 8;
    localparam int DEF_RESET_VEC = 0;
    localparam int PC_INC        = 1;

endpackage

// File: rtl/pc_target_gen.sv
// Next-PC selection: sign-extended branch adder and jump/link priority mux.
// Purely combinational; the owning stage decides when the result is committed.
module pc_target_gen
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DISP_W = DEF_DISP_W
) (
    input  logic [ADDR_W-1:0] i_pc,
    input  logic [ADDR_W-1:0] i_inst_pc,
    input  logic [ADDR_W-1:0] i_rtarget,
    input  logic [DISP_W-1:0] i_disp,
    input  logic              i_jal,
    input  logic              i_jmp,
    input  logic              i_branch,
    input  logic              i_next_inst,
    output logic [ADDR_W-1:0] o_next_pc,
    output logic              o_load_link,
    output logic              o_load_inst,
    output logic              o_redirect_next
);

    logic [ADDR_W-1:0] w_disp_sext;
    logic [ADDR_W-1:0] w_branch_tgt;
    logic [ADDR_W-1:0] w_seq_pc;

    assign w_disp_sext  = {{(ADDR_W-DISP_W){i_disp[DISP_W-1]}}, i_disp};
    // Branches are relative to the executing instruction, not the advanced PC.
    assign w_branch_tgt = i_inst_pc + w_disp_sext;
    assign w_seq_pc     = i_pc + ADDR_W'(PC_INC);

    always_comb begin
        o_next_pc       = i_pc;
        o_load_link     = 1'b0;
        o_load_inst     = 1'b0;
        o_redirect_next = 1'b0;
        if (i_jal) begin
            o_next_pc       = i_rtarget;
            o_load_link     = 1'b1;
            o_redirect_next = 1'b1;
        end else if (i_jmp) begin
            o_next_pc       = i_rtarget;
            o_redirect_next = 1'b1;
        end else if (i_branch) begin
            o_next_pc       = w_branch_tgt;
            o_redirect_next = 1'b1;
        end else if (i_next_inst) begin
            o_next_pc   = w_seq_pc;
            o_load_inst = 1'b1;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: PC, in-flight instruction address and JAL link.
// Commits pc_target_gen results under FSM strobes, with stall and reset gating.
module pc_unit
    import pc_unit_pkg::*;
#(
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DISP_W    = DEF_DISP_W,
    parameter int RESET_VEC = DEF_RESET_VEC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCEN,
    input  logic              PCinstruction,
    input  logic              nextInstruction,
    input  logic              BranchEN,
    input  logic              JmpEN,
    input  logic              JALEN,
    input  logic              stall,
    input  logic [DISP_W-1:0] disp,
    input  logic [ADDR_W-1:0] rtarget,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] inst_pc,
    output logic [ADDR_W-1:0] link,
    output logic              redirect
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_inst_pc;
    logic [ADDR_W-1:0] r_link;
    logic              r_redirect;

    logic [ADDR_W-1:0] w_next_pc;
    logic              w_load_link;
    logic              w_load_inst;
    logic              w_redirect_next;
    logic              w_update;

    assign w_update = PCEN && PCinstruction && !stall;

    pc_target_gen #(
        .ADDR_W (ADDR_W),
        .DISP_W (DISP_W)
    ) u_tgt (
        .i_pc            (r_pc),
        .i_inst_pc       (r_inst_pc),
        .i_rtarget       (rtarget),
        .i_disp          (disp),
        .i_jal           (JALEN),
        .i_jmp           (JmpEN),
        .i_branch        (BranchEN),
        .i_next_inst     (nextInstruction),
        .o_next_pc       (w_next_pc),
        .o_load_link     (w_load_link),
        .o_load_inst     (w_load_inst),
        .o_redirect_next (w_redirect_next)
    );

    // Reset wins over stall so a wedged memory wait cannot block restart.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pc       <= ADDR_W'(RESET_VEC);
            r_inst_pc  <= ADDR_W'(RESET_VEC);
            r_link     <= '0;
            r_redirect <= 1'b0;
        end else if (w_update) begin
            r_pc       <= w_next_pc;
            r_redirect <= w_redirect_next;
            if (w_load_inst) begin
                r_inst_pc <= r_pc;
            end
            if (w_load_link) begin
                r_link <= r_pc;
            end
        end else begin
            r_redirect <= 1'b0;
        end
    end

    assign pc       = r_pc;
    assign inst_pc  = r_inst_pc;
    assign link     = r_link;
    assign redirect = r_redirect;

endmodule

// File: tb/tb_pc_unit.sv
// Directed vector bench for pc_unit: a stepped table of strobes and
// expected register values, plus a back-to-back redirect sequence.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCEN;
    logic        PCinstruction;
    logic        nextInstruction;
    logic        BranchEN;
    logic        JmpEN;
    logic        JALEN;
    logic        stall;
    logic [7:0]  disp;
    logic [15:0] rtarget;
    logic [15:0] pc;
    logic [15:0] inst_pc;
    logic [15:0] link;
    logic        redirect;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic        rst_n;
        logic        pcen;
        logic        pcins;
        logic        nxt;
        logic        br;
        logic        jmp;
        logic        jal;
        logic        stl;
        logic [7:0]  d;
        logic [15:0] rt;
        logic [15:0] e_pc;
        logic [15:0] e_ipc;
        logic [15:0] e_link;
        logic        e_red;
    } vec_t;

    vec_t tbl[$];

    pc_unit dut (
        .clk             (clk),
        .reset           (reset),
        .PCEN            (PCEN),
        .PCinstruction   (PCinstruction),
        .nextInstruction (nextInstruction),
        .BranchEN        (BranchEN),
        .JmpEN           (JmpEN),
        .JALEN           (JALEN),
        .stall           (stall),
        .disp            (disp),
        .rtarget         (rtarget),
        .pc              (pc),
        .inst_pc         (inst_pc),
        .link            (link),
        .redirect        (redirect)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(
        input string nm,
        input logic r, input logic en, input logic pi, input logic nx,
        input logic b, input logic j, input logic jl, input logic s,
        input logic [7:0] d, input logic [15:0] rt,
        input logic [15:0] epc, input logic [15:0] eipc,
        input logic [15:0] elink, input logic ered);
        vec_t v;
        v.name = nm; v.rst_n = r; v.pcen = en; v.pcins = pi; v.nxt = nx;
        v.br = b; v.jmp = j; v.jal = jl; v.stl = s; v.d = d; v.rt = rt;
        v.e_pc = epc; v.e_ipc = eipc; v.e_link = elink; v.e_red = ered;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act,
                       input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        @(negedge clk);
        reset           = v.rst_n;
        PCEN            = v.pcen;
        PCinstruction   = v.pcins;
        nextInstruction = v.nxt;
        BranchEN        = v.br;
        JmpEN           = v.jmp;
        JALEN           = v.jal;
        stall           = v.stl;
        disp            = v.d;
        rtarget         = v.rt;
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input vec_t v);
        chk({v.name, ".pc"}, pc, v.e_pc);
        chk({v.name, ".inst_pc"}, inst_pc, v.e_ipc);
        chk({v.name, ".link"}, link, v.e_link);
        chk({v.name, ".redirect"}, {15'd0, redirect}, {15'd0, v.e_red});
    endtask

    initial begin
        //          name       rst en pi nx br jp jl st disp   rtarget  pc       inst_pc  link     red
        tbl.push_back(mk("reset",   0,0,0,0,0,0,0,0, 8'h00, 16'h0000, 16'h0000,16'h0000,16'h0000,0));
        tbl.push_back(mk("fetch1",  1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0001,16'h0000,16'h0000,0));
        tbl.push_back(mk("fetch2",  1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0002,16'h0001,16'h0000,0));
        tbl.push_back(mk("fetch3",  1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0003,16'h0002,16'h0000,0));
        tbl.push_back(mk("jmp10",   1,1,1,0,0,1,0,0, 8'h00, 16'h0010, 16'h0010,16'h0002,16'h0000,1));
        tbl.push_back(mk("fetch10", 1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0011,16'h0010,16'h0000,0));
        tbl.push_back(mk("brneg4",  1,1,1,0,1,0,0,0, 8'hFC, 16'h0000, 16'h000C,16'h0010,16'h0000,1));
        tbl.push_back(mk("idle",    1,0,0,0,0,0,0,0, 8'h00, 16'h0000, 16'h000C,16'h0010,16'h0000,0));
        tbl.push_back(mk("nottaken",1,1,1,0,0,0,0,0, 8'h00, 16'h0000, 16'h000C,16'h0010,16'h0000,0));
        tbl.push_back(mk("jmp20",   1,1,1,0,0,1,0,0, 8'h00, 16'h0020, 16'h0020,16'h0010,16'h0000,1));
        tbl.push_back(mk("fetch20", 1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0021,16'h0020,16'h0000,0));
        tbl.push_back(mk("jal400",  1,1,1,0,0,0,1,0, 8'h00, 16'h0400, 16'h0400,16'h0020,16'h0021,1));
        tbl.push_back(mk("fetch400",1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0401,16'h0400,16'h0021,0));
        tbl.push_back(mk("jmpret",  1,1,1,0,0,1,0,0, 8'h00, 16'h0021, 16'h0021,16'h0400,16'h0021,1));
        tbl.push_back(mk("stallfet",1,1,1,1,0,0,0,1, 8'h00, 16'h0000, 16'h0021,16'h0400,16'h0021,0));
        tbl.push_back(mk("stalljal",1,1,1,0,0,0,1,1, 8'h00, 16'h0999, 16'h0021,16'h0400,16'h0021,0));
        tbl.push_back(mk("brnoen",  1,0,1,0,1,0,0,0, 8'h05, 16'h0000, 16'h0021,16'h0400,16'h0021,0));
        tbl.push_back(mk("jalnoen", 1,0,1,0,0,0,1,0, 8'h00, 16'h0777, 16'h0021,16'h0400,16'h0021,0));
        tbl.push_back(mk("jmpffff", 1,1,1,0,0,1,0,0, 8'h00, 16'hFFFF, 16'hFFFF,16'h0400,16'h0021,1));
        tbl.push_back(mk("wrapinc", 1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0000,16'hFFFF,16'h0021,0));
        tbl.push_back(mk("fetch0",  1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0001,16'h0000,16'h0021,0));
        tbl.push_back(mk("brwrap",  1,1,1,0,1,0,0,0, 8'hFF, 16'h0000, 16'hFFFF,16'h0000,16'h0021,1));
        tbl.push_back(mk("prio_jal",1,1,1,0,1,1,1,0, 8'h10, 16'h0123, 16'h0123,16'h0000,16'hFFFF,1));
        tbl.push_back(mk("prio_jmp",1,1,1,0,1,1,0,0, 8'h10, 16'h0200, 16'h0200,16'h0000,16'hFFFF,1));
        tbl.push_back(mk("prio_br", 1,1,1,1,1,0,0,0, 8'h02, 16'h0000, 16'h0002,16'h0000,16'hFFFF,1));
        tbl.push_back(mk("rstjal",  0,1,1,0,0,0,1,0, 8'h00, 16'h0555, 16'h0000,16'h0000,16'h0000,0));
        tbl.push_back(mk("refetch", 1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0001,16'h0000,16'h0000,0));
        tbl.push_back(mk("jal40",   1,1,1,0,0,0,1,0, 8'h00, 16'h0040, 16'h0040,16'h0000,16'h0001,1));
        tbl.push_back(mk("rststall",0,1,1,1,0,0,0,1, 8'h00, 16'h0000, 16'h0000,16'h0000,16'h0000,0));
        tbl.push_back(mk("fetchrv", 1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0001,16'h0000,16'h0000,0));

        reset = 1'b0; PCEN = 1'b0; PCinstruction = 1'b0;
        nextInstruction = 1'b0; BranchEN = 1'b0; JmpEN = 1'b0;
        JALEN = 1'b0; stall = 1'b0; disp = '0; rtarget = '0;

        foreach (tbl[i]) begin
            drive(tbl[i]);
            check_vec(tbl[i]);
        end

        // Back-to-back redirects hold redirect high, then a stall drops it.
        drive(mk("b2b_a", 1,1,1,0,0,1,0,0, 8'h00, 16'h0300, 16'h0300,16'h0000,16'h0000,1));
        check_vec(mk("b2b_a", 1,1,1,0,0,1,0,0, 8'h00, 16'h0300, 16'h0300,16'h0000,16'h0000,1));
        drive(mk("b2b_b", 1,1,1,0,0,0,1,0, 8'h00, 16'h0310, 16'h0310,16'h0000,16'h0300,1));
        check_vec(mk("b2b_b", 1,1,1,0,0,0,1,0, 8'h00, 16'h0310, 16'h0310,16'h0000,16'h0300,1));
        drive(mk("b2b_st", 1,1,1,0,0,1,0,1, 8'h00, 16'h0555, 16'h0310,16'h0000,16'h0300,0));
        check_vec(mk("b2b_st", 1,1,1,0,0,1,0,1, 8'h00, 16'h0555, 16'h0310,16'h0000,16'h0300,0));

        // Positive branch from a fetched instruction, then release with no strobe.
        drive(mk("pf", 1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0311,16'h0310,16'h0300,0));
        check_vec(mk("pf", 1,1,1,1,0,0,0,0, 8'h00, 16'h0000, 16'h0311,16'h0310,16'h0300,0));
        drive(mk("bpos", 1,1,1,0,1,0,0,0, 8'h7F, 16'h0000, 16'h038F,16'h0310,16'h0300,1));
        check_vec(mk("bpos", 1,1,1,0,1,0,0,0, 8'h7F, 16'h0000, 16'h038F,16'h0310,16'h0300,1));
        drive(mk("drop", 1,0,0,0,0,0,0,0, 8'h00, 16'h0000, 16'h038F,16'h0310,16'h0300,0));
        check_vec(mk("drop", 1,0,0,0,0,0,0,0, 8'h00, 16'h0000, 16'h038F,16'h0310,16'h0300,0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
